dmem_responder: RTL and testbench

Data-memory responder for the RV32I core's load/store port: it answers the requests the core issues. It accepts one request at a time over a valid/ready handshake and performs byte, halfword or word accesses on an internal word-organised RAM. Loads return sign- or zero-extended data; stores write only the addressed byte lanes. A fixed, configurable number of wait states sits between request and response, so the core's stall logic can be exercised with non-zero memory latency.

---
 rtl/dmem_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32I load/store port.
// Latency: response strobe LATENCY+1 cycles after accept; one request per LATENCY+2 cycles.
// Backpressure: req_ready is high only in IDLE; there is no response backpressure.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   req_valid     request present
//   req_ready     responder can accept (IDLE only)
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  zero-extend byte/half loads
//   rsp_valid     one-cycle response strobe
//   rsp_rdata     extended load data (0 for stores and faults)
//   rsp_err       access fault, qualified by rsp_valid
//
// Build option: define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word
// accesses; otherwise the low address bits are forced to natural alignment.

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_U  = 32'(DEPTH_WORDS);
  localparam logic        ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0]  LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Word-organised storage; contents are deliberately not reset.
  logic [31:0] r_mem [DEPTH_WORDS];

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  // Operation currently being resolved: straight from the request port while
  // idle (needed when LATENCY=0 commits on the accept edge), else the latched copy.
  logic        w_in_idle;
  logic        w_op_we;
  logic [31:0] w_op_addr;
  logic [31:0] w_op_wdata;
  logic [1:0]  w_op_size;
  logic        w_op_unsigned;

  logic        w_range_err;
  logic        w_align_err;
  logic        w_err;
  logic [1:0]  w_off;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rd_word;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;
  logic [31:0] w_load_data;
  logic [3:0]  w_be;
  logic [31:0] w_wdat;
  logic        w_enter_resp;
  logic        w_mem_we;

  assign w_in_idle     = (r_state == S_IDLE);
  assign w_op_we       = w_in_idle ? req_we       : r_we;
  assign w_op_addr     = w_in_idle ? req_addr     : r_addr;
  assign w_op_wdata    = w_in_idle ? req_wdata    : r_wdata;
  assign w_op_size     = w_in_idle ? req_size     : r_size;
  assign w_op_unsigned = w_in_idle ? req_unsigned : r_unsigned;

  // The edge that moves the FSM into RESP is the commit point for stores and
  // the capture point for load data.
  assign w_enter_resp = (w_in_idle && req_valid && ZERO_LAT) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // Address decode and fault detection.
  always_comb begin
    w_range_err = ({2'b00, w_op_addr[31:2]} >= DEPTH_U);
`ifdef DMEM_MISALIGN_CHECK_EN
    w_align_err = ((w_op_size == 2'b01) && w_op_addr[0]) ||
                  ((w_op_size == 2'b10) && (w_op_addr[1:0] != 2'b00));
    w_off       = w_op_addr[1:0];
`else
    w_align_err = 1'b0;
    case (w_op_size)
      2'b00:   w_off = w_op_addr[1:0];
      2'b01:   w_off = {w_op_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
`endif
    w_err = w_range_err || w_align_err || (w_op_size == 2'b11);
    w_idx = w_op_addr[AW+1:2];
  end

  // Load path: align the addressed lane(s) to bit 0, then extend.
  assign w_rd_word = r_mem[w_idx];
  assign w_shifted = w_rd_word >> {w_off, 3'b000};

  always_comb begin
    case (w_op_size)
      2'b00:   w_ext = w_op_unsigned ? {24'h0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_ext = w_op_unsigned ? {16'h0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_rd_word;
    endcase
    w_load_data = (w_err || w_op_we) ? 32'h0 : w_ext;
  end

  // Store path: replicate data across lanes, enable only the addressed ones.
  always_comb begin
    case (w_op_size)
      2'b00: begin
        w_be   = 4'b0001 << w_off;
        w_wdat = {4{w_op_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{w_op_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wdat = w_op_wdata;
      end
    endcase
  end

  // rst gates the write so that a request presented during reset never commits.
  assign w_mem_we = w_enter_resp && w_op_we && !w_err && rst;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_mem_we && w_be[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_ready    <= 1'b0;
            if (ZERO_LAT) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_load_data;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_load_data;
            r_rsp_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Shared stimulus for the latency-sweep instances.
  logic        s_valid = 1'b0;
  logic        l0_ready, l0_valid, l0_err;
  logic [31:0] l0_rdata;
  logic        l3_ready, l3_valid, l3_err;
  logic [31:0] l3_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [256];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(l0_ready),
    .req_we(1'b1), .req_addr(32'h0), .req_wdata(32'h1234_5678),
    .req_size(2'b10), .req_unsigned(1'b0), .rsp_valid(l0_valid),
    .rsp_rdata(l0_rdata), .rsp_err(l0_err));

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(l3_ready),
    .req_we(1'b1), .req_addr(32'h0), .req_wdata(32'h1234_5678),
    .req_size(2'b10), .req_unsigned(1'b0), .rsp_valid(l3_valid),
    .rsp_rdata(l3_rdata), .rsp_err(l3_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic m_err(input logic [31:0] a, input logic [1:0] sz);
    logic e;
    e = ((a / 4) >= 256) || (sz == 2'd3);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (sz == 2'd1 && (a % 2) != 0) e = 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int m_off(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return int'(a % 4);
    if (sz == 2'd1) return int'(((a % 4) / 2) * 2);
    return 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                         input logic uns);
    logic [31:0] w, v;
    w = mdl[a / 4];
    v = w >> (8 * m_off(a, sz));
    if (sz == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] mask;
    int off;
    off = m_off(a, sz);
    if (sz == 2'd0)      mask = 32'hFF << (8 * off);
    else if (sz == 2'd1) mask = 32'hFFFF << (8 * off);
    else                 mask = 32'hFFFF_FFFF;
    mdl[a / 4] = (mdl[a / 4] & ~mask) | ((d << (8 * off)) & mask);
  endtask

  // One request on the main instance; checks ready at issue and the latency.
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic uns,
                      output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    chk("ready_at_issue", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    req_size = sz; req_unsigned = uns;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      chk("ready_low_busy", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(LAT + 1));
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic run_model_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, input logic uns);
    logic [31:0] rd, exp_d;
    logic er, exp_e;
    exp_e = m_err(a, sz);
    exp_d = (exp_e || we) ? 32'h0 : m_load(a, sz, uns);
    xact(we, a, d, sz, uns, rd, er);
    chk("rnd_err", {31'b0, er}, {31'b0, exp_e});
    chk("rnd_data", rd, exp_d);
    if (we && !exp_e) m_store(a, d, sz);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int last0, last3;
    logic e0, e3;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   {31'b0, rsp_err}, 32'd0);

    // Fill RAM so every later load has a known reference value.
    for (int i = 0; i < 256; i++) begin
      mdl[i] = $urandom;
      xact(1'b1, 32'(i * 4), mdl[i], 2'd2, 1'b0, rd, er);
    end

    // Word store then load
    xact(1'b1, 32'h10, 32'h8000_00F1, 2'd2, 1'b0, rd, er);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", {31'b0, er}, 32'd0);
    m_store(32'h10, 32'h8000_00F1, 2'd2);
    xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er);
    chk("lw_10", rd, 32'h8000_00F1);

    // Byte/half lanes
    xact(1'b1, 32'h20, 32'h1122_3384, 2'd2, 1'b0, rd, er);
    m_store(32'h20, 32'h1122_3384, 2'd2);
    xact(1'b0, 32'h20, 32'h0, 2'd0, 1'b0, rd, er);
    chk("lb_20", rd, 32'hFFFF_FF84);
    xact(1'b0, 32'h20, 32'h0, 2'd0, 1'b1, rd, er);
    chk("lbu_20", rd, 32'h0000_0084);
    xact(1'b0, 32'h22, 32'h0, 2'd1, 1'b0, rd, er);
    chk("lh_22", rd, 32'h0000_1122);
    xact(1'b1, 32'h21, 32'h0000_00AB, 2'd0, 1'b0, rd, er);
    m_store(32'h21, 32'h0000_00AB, 2'd0);
    xact(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd, er);
    chk("lw_20_after_sb", rd, 32'h1122_AB84);

    // Out of range
    xact(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, rd, er);
    chk("oor_err", {31'b0, er}, 32'd1);
    chk("oor_rdata", rd, 32'h0);
    xact(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, rd, er);
    chk("lw0_err", {31'b0, er}, 32'd0);
    chk("lw0_rdata", rd, mdl[0]);

    // Misaligned word load
    xact(1'b0, 32'h13, 32'h0, 2'd2, 1'b0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("mis_err", {31'b0, er}, 32'd1);
    chk("mis_rdata", rd, 32'h0);
`else
    chk("mis_err", {31'b0, er}, 32'd0);
    chk("mis_rdata", rd, 32'h8000_00F1);
`endif

    // Reset while a store to 0x10 waits: no response, no write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
    req_wdata = 32'hDEAD_BEEF; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_novalid", {31'b0, rsp_valid}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_novalid", {31'b0, rsp_valid}, 32'd0);
    end
    xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd, er);
    chk("rst_store_dropped", rd, 32'h8000_00F1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [1:0] sz;
      a  = ($urandom_range(0, 9) == 0) ? (32'h400 + ($urandom % 32'h1000)) : 32'($urandom_range(0, 1023));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_model_op(1'($urandom), a, $urandom, sz, 1'($urandom));
    end

    // Latency sweep with req_valid held high: LATENCY=0 and LATENCY=3
    @(negedge clk);
    s_valid = 1'b1;
    last0 = -1;
    last3 = -1;
    for (int c = 0; c < 40; c++) begin
      e0 = (last0 < 0) || (c - last0 >= 2);
      e3 = (last3 < 0) || (c - last3 >= 5);
      chk("l0_ready", {31'b0, l0_ready}, {31'b0, e0});
      chk("l0_valid", {31'b0, l0_valid}, {31'b0, (last0 >= 0) && (c - last0 == 1)});
      chk("l3_ready", {31'b0, l3_ready}, {31'b0, e3});
      chk("l3_valid", {31'b0, l3_valid}, {31'b0, (last3 >= 0) && (c - last3 == 4)});
      if (l0_valid) chk("l0_err", {31'b0, l0_err}, 32'd0);
      if (l3_valid) chk("l3_err", {31'b0, l3_err}, 32'd0);
      if (e0) last0 = c;
      if (e3) last3 = c;
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
